// File: rtl/tcdm_xbar_rr_if.sv
// Bus bundle for tcdm_xbar_rr: flat packed master-side request/response and bank-side signals.
// m_prio_i exists only when TCDM_XBAR_PRIO_EN is defined.
interface tcdm_xbar_rr_if #(
   parameter int unsigned NUM_MASTER = 4,
   parameter int unsigned NUM_SLAVE  = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
);
   logic [NUM_MASTER-1:0]            m_req_i;
   logic [NUM_MASTER-1:0]            m_we_i;
   logic [NUM_MASTER*ADDR_WIDTH-1:0] m_addr_i;
   logic [NUM_MASTER*DATA_WIDTH-1:0] m_wdata_i;
   logic [NUM_MASTER*BE_WIDTH-1:0]   m_be_i;
   logic [NUM_MASTER-1:0]            m_gnt_o;
   logic [NUM_MASTER-1:0]            m_rvalid_o;
   logic [NUM_MASTER*DATA_WIDTH-1:0] m_rdata_o;
`ifdef TCDM_XBAR_PRIO_EN
   logic [NUM_MASTER-1:0]            m_prio_i;
`endif
   logic [NUM_SLAVE-1:0]             s_req_o;
   logic [NUM_SLAVE-1:0]             s_we_o;
   logic [NUM_SLAVE*ADDR_WIDTH-1:0]  s_addr_o;
   logic [NUM_SLAVE*DATA_WIDTH-1:0]  s_wdata_o;
   logic [NUM_SLAVE*BE_WIDTH-1:0]    s_be_o;
   logic [NUM_SLAVE-1:0]             s_gnt_i;
   logic [NUM_SLAVE*DATA_WIDTH-1:0]  s_rdata_i;

   // Crossbar side
   modport slave (
`ifdef TCDM_XBAR_PRIO_EN
      input  m_prio_i,
`endif
      input  m_req_i, m_we_i, m_addr_i, m_wdata_i, m_be_i, s_gnt_i, s_rdata_i,
      output m_gnt_o, m_rvalid_o, m_rdata_o, s_req_o, s_we_o, s_addr_o, s_wdata_o, s_be_o
   );

   // Environment side: masters and banks
   modport master (
`ifdef TCDM_XBAR_PRIO_EN
      output m_prio_i,
`endif
      output m_req_i, m_we_i, m_addr_i, m_wdata_i, m_be_i, s_gnt_i, s_rdata_i,
      input  m_gnt_o, m_rvalid_o, m_rdata_o, s_req_o, s_we_o, s_addr_o, s_wdata_o, s_be_o
   );
endinterface

// File: rtl/tcdm_xbar_rr.sv
// NUM_MASTER x NUM_SLAVE word-interleaved TCDM crossbar with per-bank round-robin arbitration
// and one-cycle response routing. Define TCDM_XBAR_PRIO_EN to add per-master priority requests.
module tcdm_xbar_rr #(
   parameter int unsigned NUM_MASTER       = 4,
   parameter int unsigned NUM_SLAVE        = 4,
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned ADDR_WIDTH       = 32,
   parameter int unsigned BE_WIDTH         = DATA_WIDTH / 8,
   parameter int unsigned INTERLEAVE_WORDS = 1
) (
   input logic           clk_i,
   input logic           rst_i,
   tcdm_xbar_rr_if.slave bus
);
   localparam int unsigned BYTE_OFF  = $clog2(BE_WIDTH);
   localparam int unsigned BANK_LSB  = BYTE_OFF + $clog2(INTERLEAVE_WORDS);
   localparam int unsigned BANK_BITS = $clog2(NUM_SLAVE);
   localparam int unsigned SEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
   localparam int unsigned MST_W     = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;
   localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((64'(1) << BANK_LSB) - 64'(1));

   logic [SEL_W-1:0]      m_bank   [NUM_MASTER];
   logic [ADDR_WIDTH-1:0] m_addr_c [NUM_MASTER];
   logic [NUM_MASTER-1:0] prio;
   logic [NUM_MASTER-1:0] tgt      [NUM_SLAVE];
   logic [NUM_MASTER-1:0] cand     [NUM_SLAVE];
   logic [MST_W-1:0]      win      [NUM_SLAVE];
   logic [MST_W-1:0]      rr_q     [NUM_SLAVE];
   logic [MST_W-1:0]      resp_mst_q [NUM_SLAVE];
   logic [NUM_SLAVE-1:0]  resp_vld_q;
   logic [NUM_SLAVE-1:0]  s_req;
   logic [NUM_SLAVE-1:0]  hs;
   logic [NUM_SLAVE-1:0]  s_we;
   logic [NUM_SLAVE*ADDR_WIDTH-1:0]  s_addr;
   logic [NUM_SLAVE*DATA_WIDTH-1:0]  s_wdata;
   logic [NUM_SLAVE*BE_WIDTH-1:0]    s_be;
   logic [NUM_MASTER-1:0]            gnt;
   logic [NUM_MASTER-1:0]            rvalid;
   logic [NUM_MASTER*DATA_WIDTH-1:0] rdata;
   int unsigned idx;

   // Bank decode and compaction: bank bits are squeezed out of the address the bank sees
   for (genvar m = 0; m < NUM_MASTER; m++) begin : g_mst
      logic [ADDR_WIDTH-1:0] addr;
      assign addr = bus.m_addr_i[m*ADDR_WIDTH +: ADDR_WIDTH];
      if (BANK_BITS > 0) begin : g_sel
         assign m_bank[m]   = addr[BANK_LSB +: BANK_BITS];
         assign m_addr_c[m] = ((addr >> (BANK_LSB + BANK_BITS)) << BANK_LSB) | (addr & LOW_MASK);
      end else begin : g_one
         assign m_bank[m]   = '0;
         assign m_addr_c[m] = addr;
      end
   end

`ifdef TCDM_XBAR_PRIO_EN
   assign prio = bus.m_prio_i;
`else
   assign prio = '0;
`endif

   // Candidates per bank; any high-priority requester masks out the normal ones
   always_comb begin
      for (int s = 0; s < int'(NUM_SLAVE); s++) begin
         tgt[s] = '0;
         for (int m = 0; m < int'(NUM_MASTER); m++) begin
            tgt[s][m] = bus.m_req_i[m] && (m_bank[m] == SEL_W'(s));
         end
         cand[s] = ((tgt[s] & prio) != '0) ? (tgt[s] & prio) : tgt[s];
      end
   end

   // Round-robin pick: scanning offsets downwards lets the nearest one to rr_q win last
   always_comb begin
      s_req = '0;
      idx   = 0;
      for (int s = 0; s < int'(NUM_SLAVE); s++) begin
         win[s]   = '0;
         s_req[s] = |cand[s];
         for (int off = int'(NUM_MASTER) - 1; off >= 0; off--) begin
            idx = 32'(rr_q[s]) + 32'(off);
            if (idx >= NUM_MASTER) idx = idx - NUM_MASTER;
            if (cand[s][idx]) win[s] = MST_W'(idx);
         end
      end
   end

   // Bank-side mux of the winning master's payload
   always_comb begin
      s_we    = '0;
      s_addr  = '0;
      s_wdata = '0;
      s_be    = '0;
      for (int s = 0; s < int'(NUM_SLAVE); s++) begin
         if (s_req[s]) begin
            s_we[s]                                = bus.m_we_i[win[s]];
            s_addr[s*ADDR_WIDTH +: ADDR_WIDTH]     = m_addr_c[win[s]];
            s_wdata[s*DATA_WIDTH +: DATA_WIDTH]    = bus.m_wdata_i[32'(win[s])*DATA_WIDTH +: DATA_WIDTH];
            s_be[s*BE_WIDTH +: BE_WIDTH]           = bus.m_be_i[32'(win[s])*BE_WIDTH +: BE_WIDTH];
         end
      end
   end

   assign hs = s_req & bus.s_gnt_i;

   always_comb begin
      gnt = '0;
      for (int s = 0; s < int'(NUM_SLAVE); s++) begin
         if (hs[s]) gnt[win[s]] = 1'b1;
      end
   end

   // Pointer advance and response capture on each bank handshake
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         resp_vld_q <= '0;
         for (int s = 0; s < int'(NUM_SLAVE); s++) begin
            rr_q[s]       <= '0;
            resp_mst_q[s] <= '0;
         end
      end else begin
         resp_vld_q <= hs;
         for (int s = 0; s < int'(NUM_SLAVE); s++) begin
            if (hs[s]) begin
               resp_mst_q[s] <= win[s];
               rr_q[s]       <= (win[s] == MST_W'(NUM_MASTER - 1)) ? '0 : win[s] + MST_W'(1);
            end
         end
      end
   end

   // Response routing; held off while in reset so in-flight responses are dropped
   always_comb begin
      rvalid = '0;
      rdata  = '0;
      if (!rst_i) begin
         for (int s = 0; s < int'(NUM_SLAVE); s++) begin
            if (resp_vld_q[s]) begin
               rvalid[resp_mst_q[s]] = 1'b1;
               rdata[32'(resp_mst_q[s])*DATA_WIDTH +: DATA_WIDTH] =
                  bus.s_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   assign bus.s_req_o    = s_req;
   assign bus.s_we_o     = s_we;
   assign bus.s_addr_o   = s_addr;
   assign bus.s_wdata_o  = s_wdata;
   assign bus.s_be_o     = s_be;
   assign bus.m_gnt_o    = gnt;
   assign bus.m_rvalid_o = rvalid;
   assign bus.m_rdata_o  = rdata;
endmodule

// File: tb/tb_tcdm_xbar_rr.sv
// Scoreboard bench for tcdm_xbar_rr: directed request vectors, queued expected responses,
// and a negedge monitor popping them as rvalid appears. Prio case runs with TCDM_XBAR_PRIO_EN.
module tb_tcdm_xbar_rr;
   typedef struct {
      int          mst;
      bit          we;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rst;
   logic rst_v;
   int   n_cmp;
   int   n_err;
   exp_t sb [$];
   exp_t mon_e;

   logic [31:0] addr  [4];
   logic [31:0] wdata [4];
   logic [3:0]  be    [4];
   logic [3:0]  we;

   tcdm_xbar_rr_if #(.NUM_MASTER(4), .NUM_SLAVE(4), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
   tcdm_xbar_rr_if #(.NUM_MASTER(4), .NUM_SLAVE(4), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2 ();

   tcdm_xbar_rr #(.NUM_MASTER(4), .NUM_SLAVE(4), .DATA_WIDTH(32), .ADDR_WIDTH(32),
                  .INTERLEAVE_WORDS(1)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   tcdm_xbar_rr #(.NUM_MASTER(4), .NUM_SLAVE(4), .DATA_WIDTH(32), .ADDR_WIDTH(32),
                  .INTERLEAVE_WORDS(2)) dut_iw2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] bank_of(input logic [31:0] a);
      return a[3:2];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // One clock of stimulus; grant is checked in-cycle, responses are queued for the monitor
   task automatic step(input logic [3:0] req, input logic [3:0] sgnt, input logic [3:0] exp_gnt,
                       input bit push, input string nm);
      @(posedge clk);
      #1;
      rst             = rst_v;
      bus.m_req_i     = req;
      bus.s_gnt_i     = sgnt;
      bus.m_we_i      = we;
      bus.m_addr_i    = {addr[3], addr[2], addr[1], addr[0]};
      bus.m_wdata_i   = {wdata[3], wdata[2], wdata[1], wdata[0]};
      bus.m_be_i      = {be[3], be[2], be[1], be[0]};
      #2;
      chk({nm, "_gnt"}, 64'(bus.m_gnt_o), 64'(exp_gnt));
      if (push) begin
         for (int m = 0; m < 4; m++) begin
            if (exp_gnt[m]) sb.push_back('{m, we[m], 32'hD000_0000 | 32'(bank_of(addr[m]))});
         end
      end
   endtask

   // Response monitor
   always @(negedge clk) begin
      for (int m = 0; m < 4; m++) begin
         if (bus.m_rvalid_o[m]) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL rsp_unexpected: master %0d rvalid=1 expected 0", m);
            end else begin
               mon_e = sb.pop_front();
               if (mon_e.mst != m) begin
                  n_err++;
                  $display("FAIL rsp_master: got master %0d expected master %0d", m, mon_e.mst);
               end else if (!mon_e.we && bus.m_rdata_o[m*32 +: 32] !== mon_e.data) begin
                  n_err++;
                  $display("FAIL rsp_rdata m%0d: got 0x%0h expected 0x%0h", m,
                           bus.m_rdata_o[m*32 +: 32], mon_e.data);
               end
            end
         end else if (!rst) begin
            chk($sformatf("rdata_idle_m%0d", m), 64'(bus.m_rdata_o[m*32 +: 32]), 64'(0));
         end
      end
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      rst_v = 1'b1;
      we    = '0;
      for (int m = 0; m < 4; m++) begin
         addr[m]  = '0;
         wdata[m] = '0;
         be[m]    = 4'hF;
      end
      bus.m_req_i   = '0;
      bus.m_we_i    = '0;
      bus.m_addr_i  = '0;
      bus.m_wdata_i = '0;
      bus.m_be_i    = '0;
      bus.s_gnt_i   = '0;
      bus.s_rdata_i = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
      bus2.m_req_i   = '0;
      bus2.m_we_i    = '0;
      bus2.m_addr_i  = '0;
      bus2.m_wdata_i = '0;
      bus2.m_be_i    = '0;
      bus2.s_gnt_i   = '1;
      bus2.s_rdata_i = '0;
`ifdef TCDM_XBAR_PRIO_EN
      bus.m_prio_i  = '0;
      bus2.m_prio_i = '0;
`endif

      // Reset state
      step(4'b0000, 4'hF, 4'b0000, 1'b0, "rst0");
      step(4'b0000, 4'hF, 4'b0000, 1'b0, "rst1");
      chk("rst_rvalid", 64'(bus.m_rvalid_o), 64'(0));
      chk("rst_sreq",   64'(bus.s_req_o),    64'(0));
      chk("rst_rdata",  64'(bus.m_rdata_o),  64'(0));
      rst_v = 1'b0;

      // Master 0 reads 0x8 -> bank 2, compacted 0x0
      addr[0] = 32'h8;
      step(4'b0001, 4'hF, 4'b0001, 1'b1, "rd_b2");
      chk("rd_b2_sreq",  64'(bus.s_req_o), 64'(4'b0100));
      chk("rd_b2_saddr", 64'(bus.s_addr_o[2*32 +: 32]), 64'(0));

      // Two-word interleave: 0x14 -> bank 2, compacted 0x4
      bus2.m_addr_i[31:0] = 32'h14;
      bus2.m_req_i        = 4'b0001;
      #1;
      chk("iw2_sreq",  64'(bus2.s_req_o), 64'(4'b0100));
      chk("iw2_saddr", 64'(bus2.s_addr_o[2*32 +: 32]), 64'(32'h4));
      chk("iw2_gnt",   64'(bus2.m_gnt_o), 64'(4'b0001));

      // Master 1 reads 0x34 -> bank 1, compacted 0xC
      addr[1] = 32'h34;
      step(4'b0010, 4'hF, 4'b0010, 1'b1, "rd_b1");
      chk("rd_b1_saddr", 64'(bus.s_addr_o[1*32 +: 32]), 64'(32'hC));
      bus2.m_req_i = '0;

      // All four masters on bank 0: grants rotate 0,1,2,3,0
      addr[0] = 32'h00; addr[1] = 32'h10; addr[2] = 32'h20; addr[3] = 32'h30;
      step(4'hF, 4'hF, 4'b0001, 1'b1, "rr0");
      chk("rr0_saddr", 64'(bus.s_addr_o[31:0]), 64'(32'h0));
      step(4'hF, 4'hF, 4'b0010, 1'b1, "rr1");
      chk("rr1_saddr", 64'(bus.s_addr_o[31:0]), 64'(32'h4));
      step(4'hF, 4'hF, 4'b0100, 1'b1, "rr2");
      chk("rr2_saddr", 64'(bus.s_addr_o[31:0]), 64'(32'h8));
      step(4'hF, 4'hF, 4'b1000, 1'b1, "rr3");
      chk("rr3_saddr", 64'(bus.s_addr_o[31:0]), 64'(32'hC));
      step(4'hF, 4'hF, 4'b0001, 1'b1, "rr4");

      // Bank 1 stalls for three cycles, then accepts
      addr[1] = 32'h4;
      step(4'b0010, 4'b1101, 4'b0000, 1'b0, "stall0");
      chk("stall_sreq", 64'(bus.s_req_o), 64'(4'b0010));
      step(4'b0010, 4'b1101, 4'b0000, 1'b0, "stall1");
      step(4'b0010, 4'b1101, 4'b0000, 1'b0, "stall2");
      step(4'b0010, 4'hF,    4'b0010, 1'b1, "stall_go");

      // Handshake on bank 0 by master 1 (pointer -> 2), then reset drops the response
      addr[1] = 32'h10; addr[3] = 32'h30;
      step(4'b0010, 4'hF, 4'b0010, 1'b0, "pre_rst");
      rst_v = 1'b1;
      step(4'b0000, 4'hF, 4'b0000, 1'b0, "mid_rst");
      chk("mid_rst_rvalid", 64'(bus.m_rvalid_o), 64'(0));
      rst_v = 1'b0;
      // Pointer back at 0: master 1 beats master 3
      step(4'b1010, 4'hF, 4'b0010, 1'b1, "post_rst");
      chk("post_rst_rvalid", 64'(bus.m_rvalid_o), 64'(0));

      // Four banks serve four masters concurrently
      addr[0] = 32'hC; addr[1] = 32'h8; addr[2] = 32'h4; addr[3] = 32'h0;
      step(4'hF, 4'hF, 4'hF, 1'b1, "conc");
      chk("conc_sreq", 64'(bus.s_req_o), 64'(4'hF));

      // Master 2 writes 0x24 -> bank 1, compacted 0x8
      we = 4'b0100; addr[2] = 32'h24; wdata[2] = 32'hCAFE_0002; be[2] = 4'b0011;
      step(4'b0100, 4'hF, 4'b0100, 1'b1, "wr");
      chk("wr_swe",   64'(bus.s_we_o), 64'(4'b0010));
      chk("wr_saddr", 64'(bus.s_addr_o[1*32 +: 32]), 64'(32'h8));
      chk("wr_wdata", 64'(bus.s_wdata_o[1*32 +: 32]), 64'(32'hCAFE_0002));
      chk("wr_be",    64'(bus.s_be_o[1*4 +: 4]), 64'(4'b0011));
      we = '0; be[2] = 4'hF;

`ifdef TCDM_XBAR_PRIO_EN
      // Priority master 2 wins bank 3 twice while master 0 waits
      addr[0] = 32'hC; addr[2] = 32'h2C;
      bus.m_prio_i = 4'b0100;
      step(4'b0101, 4'hF, 4'b0100, 1'b1, "prio0");
      step(4'b0101, 4'hF, 4'b0100, 1'b1, "prio1");
      bus.m_prio_i = '0;
`endif

      step(4'b0000, 4'hF, 4'b0000, 1'b0, "drain0");
      step(4'b0000, 4'hF, 4'b0000, 1'b0, "drain1");
      @(negedge clk);
      #1;
      chk("sb_empty", 64'(sb.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
